// File: rtl/if_stage_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package if_pkg;

  localparam int          XLEN         = 64;
  localparam int          IMEM_AW      = 7;
  localparam logic [31:0] NOP_INSTR    = 32'h8b1f03ff;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IFID_RESET = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/branch controls, instruction ROM port and IF/ID outputs.
interface if_stage_if import if_pkg::*; #(parameter int N = 64);

  logic               stall;
  logic               flush;
  logic               pcsrc;
  logic [N-1:0]       pc_branch;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_q;
  logic [N-1:0]       if_pc;
  logic [31:0]        if_instr;
  logic               if_valid;

  modport master (
    output stall, flush, pcsrc, pc_branch, imem_q,
    input  imem_addr, if_pc, if_instr, if_valid
  );

  modport slave (
    input  stall, flush, pcsrc, pc_branch, imem_q,
    output imem_addr, if_pc, if_instr, if_valid
  );

endinterface

// File: rtl/if_stage_flopre.sv
// Generic async-reset register with load enable; used for the PC and the IF/ID word.
module flopre #(
  parameter type T       = logic,
  parameter T    RST_VAL = T'(0)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  T     i_d,
  output T     o_q
);

  T r_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   r_q <= RST_VAL;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM addressing and the IF/ID pipeline register.
// Build option: define IF_STALL_EN to honor the stall input; otherwise stall is ignored.
module if_stage import if_pkg::*; #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEF)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  if_stage_if.slave  bus
);

  logic         w_stall;
  logic [N-1:0] r_pc;
  logic [N-1:0] w_pc_next;
  logic         w_pc_en;
  logic         w_bubble;
  logic         w_ifid_en;
  if_id_t       w_ifid_next;
  if_id_t       r_ifid;

`ifdef IF_STALL_EN
  assign w_stall = bus.stall;
`else
  logic w_stall_unused;
  assign w_stall_unused = bus.stall;
  assign w_stall        = 1'b0;
`endif

  // Redirect beats stall; the branch target is forced word-aligned.
  assign w_pc_next = bus.pcsrc ? (bus.pc_branch & ~N'(3)) : (r_pc + N'(4));
  assign w_pc_en   = bus.pcsrc | ~w_stall;

  flopre #(.T(logic [N-1:0]), .RST_VAL(RESET_PC)) u_pc (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_pc_en),
    .i_d     (w_pc_next),
    .o_q     (r_pc)
  );

  // A redirect discards the wrong-path word currently being fetched.
  assign w_bubble  = bus.flush | bus.pcsrc;
  assign w_ifid_en = w_bubble | ~w_stall;

  always_comb begin
    w_ifid_next.pc = XLEN'(r_pc);
    if (w_bubble) begin
      w_ifid_next.instr = NOP_INSTR;
      w_ifid_next.valid = 1'b0;
    end else begin
      w_ifid_next.instr = bus.imem_q;
      w_ifid_next.valid = 1'b1;
    end
  end

  flopre #(.T(if_id_t), .RST_VAL(IFID_RESET)) u_ifid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_ifid_en),
    .i_d     (w_ifid_next),
    .o_q     (r_ifid)
  );

  assign bus.imem_addr = r_pc[IMEM_AW+1:2];
  assign bus.if_pc     = r_ifid.pc[N-1:0];
  assign bus.if_instr  = r_ifid.instr;
  assign bus.if_valid  = r_ifid.valid;

endmodule
